// File: rtl/masked_and_pkg.sv
// Shared definitions for the masked AND scheduler: LFSR feedback taps and FSM state encoding.
package masked_and_pkg;

  // Right-shift Galois form of x^32 + x^22 + x^2 + x + 1 (maximal length).
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    RESEED = 1'b1
  } sched_state_e;

endpackage

// File: rtl/masked_and_sched_if.sv
// Request/response bundle between share-domain clients and the masked AND scheduler.
interface masked_and_sched_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       i_req_valid;
  logic [N_REQ-1:0]       o_req_ready;
  logic [N_REQ*WIDTH-1:0] i_a0;
  logic [N_REQ*WIDTH-1:0] i_a1;
  logic [N_REQ*WIDTH-1:0] i_b0;
  logic [N_REQ*WIDTH-1:0] i_b1;
  logic                   o_rsp_valid;
  logic                   i_rsp_ready;
  logic [ID_W-1:0]        o_rsp_id;
  logic [WIDTH-1:0]       o_y0;
  logic [WIDTH-1:0]       o_y1;
  logic                   o_busy;

  modport master (
    output i_req_valid, i_a0, i_a1, i_b0, i_b1, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_id, o_y0, o_y1, o_busy
  );

  modport slave (
    input  i_req_valid, i_a0, i_a1, i_b0, i_b1, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_id, o_y0, o_y1, o_busy
  );
endinterface

// File: rtl/masked_and_pipe.sv
// Registered 2-share DOM AND stage (S2) with stall: holds its result while the consumer is not ready.
module masked_and_pipe #(
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  input  logic [ID_W-1:0]  in_id_i,
  input  logic [WIDTH-1:0] a0_i,
  input  logic [WIDTH-1:0] a1_i,
  input  logic [WIDTH-1:0] b0_i,
  input  logic [WIDTH-1:0] b1_i,
  input  logic [WIDTH-1:0] r_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ID_W-1:0]  out_id_o,
  output logic [WIDTH-1:0] y0_o,
  output logic [WIDTH-1:0] y1_o
);

  logic             valid_q, valid_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [WIDTH-1:0] y0_q, y0_d;
  logic [WIDTH-1:0] y1_q, y1_d;

  assign in_ready_o = !valid_q || out_ready_i;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    if (in_ready_o) begin
      valid_d = in_valid_i;
      if (in_valid_i) begin
        // Each share only combines its own inner term with the fresh-masked cross term.
        id_d = in_id_i;
        y0_d = (a0_i & b0_i) ^ ((a0_i & b1_i) ^ r_i);
        y1_d = (a1_i & b1_i) ^ ((a1_i & b0_i) ^ r_i);
      end
    end
  end

  // NOTE: data registers are reset as well, so no share value survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      id_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_id_o    = id_q;
  assign y0_o        = y0_q;
  assign y1_o        = y1_q;

endmodule

// File: rtl/masked_and_sched.sv
// Round-robin scheduler feeding one masked AND pipe; owns the mask LFSR, S1 registers and RUN/RESEED FSM.
// Optional reseed port enabled by defining MASKED_AND_SCHED_RESEED_EN.
module masked_and_sched
  import masked_and_pkg::*;
#(
  parameter int                N_REQ  = 4,
  parameter int                WIDTH  = 8,
  parameter int                LFSR_W = 32,
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(32'hACE1_2B5D)
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef MASKED_AND_SCHED_RESEED_EN
  input  logic              i_seed_valid,
  input  logic [LFSR_W-1:0] i_seed,
`endif
  masked_and_sched_if.slave bus
);

  localparam int                ID_W = $clog2(N_REQ);
  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(LFSR_TAPS);

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] b1;
    logic [WIDTH-1:0] r;
  } op_t;

  sched_state_e      state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic              s1_v_q, s1_v_d;
  op_t               s1_q, s1_d;

  logic              s2_ready, seed_load, grant_en, found, accept;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W:0]     cand_sum;
  logic [ID_W-1:0]   cand;

`ifdef MASKED_AND_SCHED_RESEED_EN
  assign seed_load = (state_q == RUN) && i_seed_valid;
`else
  assign seed_load = 1'b0;
`endif

  assign grant_en = (state_q == RUN) && !seed_load && (!s1_v_q || s2_ready);

  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    cand_sum = '0;
    cand     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_sum = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (cand_sum >= (ID_W+1)'(N_REQ)) cand_sum = cand_sum - (ID_W+1)'(N_REQ);
      cand = cand_sum[ID_W-1:0];
      if (!found && bus.i_req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign accept          = grant_en && found;
  assign bus.o_req_ready = accept ? (N_REQ'(1) << gnt_idx) : '0;

  always_comb begin
    s1_d   = s1_q;
    s1_v_d = s1_v_q && !s2_ready;
    ptr_d  = ptr_q;
    lfsr_d = lfsr_q;
    if (accept) begin
      s1_v_d  = 1'b1;
      s1_d.id = gnt_idx;
      s1_d.r  = lfsr_q[WIDTH-1:0];
      // Only the granted requester's shares pass the mux into S1.
      for (int k = 0; k < N_REQ; k++) begin
        if (gnt_idx == ID_W'(k)) begin
          s1_d.a0 = bus.i_a0[k*WIDTH +: WIDTH];
          s1_d.a1 = bus.i_a1[k*WIDTH +: WIDTH];
          s1_d.b0 = bus.i_b0[k*WIDTH +: WIDTH];
          s1_d.b1 = bus.i_b1[k*WIDTH +: WIDTH];
        end
      end
      ptr_d  = (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
      lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
    end
`ifdef MASKED_AND_SCHED_RESEED_EN
    if (seed_load) lfsr_d = (i_seed == '0) ? SEED : i_seed;
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (seed_load) state_d = RESEED;
      RESEED:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // NOTE: state elements use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      ptr_q   <= '0;
      lfsr_q  <= SEED;
      s1_v_q  <= 1'b0;
      s1_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lfsr_q  <= lfsr_d;
      s1_v_q  <= s1_v_d;
      s1_q    <= s1_d;
    end
  end

  masked_and_pipe #(
    .WIDTH (WIDTH),
    .ID_W  (ID_W)
  ) u_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (s1_v_q),
    .in_id_i     (s1_q.id),
    .a0_i        (s1_q.a0),
    .a1_i        (s1_q.a1),
    .b0_i        (s1_q.b0),
    .b1_i        (s1_q.b1),
    .r_i         (s1_q.r),
    .in_ready_o  (s2_ready),
    .out_valid_o (bus.o_rsp_valid),
    .out_ready_i (bus.i_rsp_ready),
    .out_id_o    (bus.o_rsp_id),
    .y0_o        (bus.o_y0),
    .y1_o        (bus.o_y1)
  );

  assign bus.o_busy = s1_v_q || bus.o_rsp_valid || (state_q != RUN);

endmodule
